// File: rtl/regfile_pkg.sv
// Shared types, defaults and helpers for the multiport register file.
package regfile_pkg;

   localparam int unsigned NR_OF_BITS_DEF       = 32;
   localparam int unsigned NR_OF_REGS_DEF       = 32;
   localparam int unsigned ADDR_BITS_DEF        = 5;
   localparam int unsigned NR_OF_READ_PORTS_DEF = 2;
   localparam int unsigned ZERO_REG_DEF         = 1;
   localparam int unsigned BYPASS_DEF           = 1;

   // Widest word byte_merge handles; callers zero-extend and truncate.
   localparam int unsigned MERGE_BITS  = 128;
   localparam int unsigned MERGE_BYTES = MERGE_BITS / 8;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Per-byte select between the stored word and new write data.
   function automatic logic [MERGE_BITS-1:0] byte_merge(
      input logic [MERGE_BITS-1:0]  old_w,
      input logic [MERGE_BITS-1:0]  new_w,
      input logic [MERGE_BYTES-1:0] be
   );
      logic [MERGE_BITS-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(MERGE_BYTES); i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/regfile_multiport_read_port.sv
// One combinational read mux with clear, zero-register and bypass masking.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned NrOfBits = NR_OF_BITS_DEF,
   parameter int unsigned NrOfRegs = NR_OF_REGS_DEF,
   parameter int unsigned AddrBits = ADDR_BITS_DEF,
   parameter int unsigned ZeroReg  = ZERO_REG_DEF,
   parameter int unsigned Bypass   = BYPASS_DEF
) (
   input  logic [AddrBits-1:0]   rd_addr_i,
   input  logic [NrOfBits-1:0]   mem_i [NrOfRegs],
   input  logic                  clearing_i,
   input  logic                  byp_valid_i,
   input  logic [AddrBits-1:0]   wr_addr_i,
   input  logic [NrOfBits-1:0]   wr_data_i,
   input  logic [NrOfBits/8-1:0] wr_byte_en_i,
   output logic [NrOfBits-1:0]   rd_data_o
);

   // Stored word, optionally overlaid by the in-flight write, then masked.
   always_comb begin
      rd_data_o = mem_i[rd_addr_i];
      if ((Bypass != 0) && byp_valid_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_o = NrOfBits'(byte_merge(MERGE_BITS'(mem_i[rd_addr_i]),
                                          MERGE_BITS'(wr_data_i),
                                          MERGE_BYTES'(wr_byte_en_i)));
      end
      if ((ZeroReg != 0) && (rd_addr_i == '0)) rd_data_o = '0;
      if (clearing_i) rd_data_o = '0;
   end

endmodule

// File: rtl/regfile_multiport.sv
// Register bank with one byte-enabled write port, N read ports and a clear engine.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int unsigned NrOfBits      = NR_OF_BITS_DEF,
   parameter int unsigned NrOfRegs      = NR_OF_REGS_DEF,
   parameter int unsigned AddrBits      = ADDR_BITS_DEF,
   parameter int unsigned NrOfReadPorts = NR_OF_READ_PORTS_DEF,
   parameter int unsigned ZeroReg       = ZERO_REG_DEF,
   parameter int unsigned Bypass        = BYPASS_DEF
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              clk_en_i,
   input  logic                              wr_en_i,
   input  logic [AddrBits-1:0]               wr_addr_i,
   input  logic [NrOfBits-1:0]               wr_data_i,
   input  logic [NrOfBits/8-1:0]             wr_byte_en_i,
   input  logic [NrOfReadPorts*AddrBits-1:0] rd_addr_i,
   output logic [NrOfReadPorts*NrOfBits-1:0] rd_data_o,
   output logic                              busy_o,
   input  logic                              clear_req_i,
   output logic                              clear_done_o
);

   state_e                state_q, state_d;
   logic [AddrBits-1:0]   cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  clr_we, wr_we;
   logic                  wr_keep, byp_valid;
   logic [NrOfBits-1:0]   mem_q [NrOfRegs];

   // A write survives only outside the hardwired-zero slot and without a competing clear.
   assign wr_keep   = (ZeroReg == 0) || (wr_addr_i != '0);
   assign byp_valid = (state_q == ST_RUN) && wr_en_i && wr_keep && !clear_req_i;

   // Next-state logic for the clear engine and array write strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      clr_we  = 1'b0;
      wr_we   = 1'b0;
      if (clk_en_i) begin
         done_d = 1'b0;
         case (state_q)
            ST_CLEAR: begin
               clr_we = 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == AddrBits'(NrOfRegs - 1)) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end
            end
            ST_RUN: begin
               if (clear_req_i) begin
                  state_d = ST_CLEAR;
                  cnt_d   = '0;
               end else if (wr_en_i && wr_keep) begin
                  wr_we = 1'b1;
               end
            end
         endcase
      end
   end

   // Control state register; reset restarts the clear sequence.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Storage array; left untouched on the reset edge itself.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (clr_we) begin
            mem_q[cnt_q] <= '0;
         end else if (wr_we) begin
            mem_q[wr_addr_i] <= NrOfBits'(byte_merge(MERGE_BITS'(mem_q[wr_addr_i]),
                                                     MERGE_BITS'(wr_data_i),
                                                     MERGE_BYTES'(wr_byte_en_i)));
         end
      end
   end

   assign busy_o       = (state_q == ST_CLEAR);
   assign clear_done_o = done_q;

   // One independent read mux per port.
   for (genvar p = 0; p < int'(NrOfReadPorts); p++) begin : g_rd
      regfile_read_port #(
         .NrOfBits (NrOfBits),
         .NrOfRegs (NrOfRegs),
         .AddrBits (AddrBits),
         .ZeroReg  (ZeroReg),
         .Bypass   (Bypass)
      ) u_rd (
         .rd_addr_i    (rd_addr_i[p*AddrBits +: AddrBits]),
         .mem_i        (mem_q),
         .clearing_i   (busy_o),
         .byp_valid_i  (byp_valid),
         .wr_addr_i    (wr_addr_i),
         .wr_data_i    (wr_data_i),
         .wr_byte_en_i (wr_byte_en_i),
         .rd_data_o    (rd_data_o[p*NrOfBits +: NrOfBits])
      );
   end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: dut_a uses ZeroReg=1/Bypass=1, dut_b uses ZeroReg=0/Bypass=0.
module tb_regfile_multiport;

   logic        clk, rst, ce, we, clr;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [3:0]  be;
   logic [9:0]  ra;
   logic [63:0] rd_a, rd_b;
   logic        busy_a, busy_b, done_a, done_b;

   int n_pass  = 0;
   int n_total = 0;

   regfile_multiport #(.ZeroReg(1), .Bypass(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .clk_en_i(ce), .wr_en_i(we), .wr_addr_i(wa),
      .wr_data_i(wd), .wr_byte_en_i(be), .rd_addr_i(ra), .rd_data_o(rd_a),
      .busy_o(busy_a), .clear_req_i(clr), .clear_done_o(done_a));

   regfile_multiport #(.ZeroReg(0), .Bypass(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .clk_en_i(ce), .wr_en_i(we), .wr_addr_i(wa),
      .wr_data_i(wd), .wr_byte_en_i(be), .rd_addr_i(ra), .rd_data_o(rd_b),
      .busy_o(busy_b), .clear_req_i(clr), .clear_done_o(done_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: cfg 0 mirrors dut_a, cfg 1 mirrors dut_b.
   logic [31:0] m_mem [2][32];
   bit          m_clear;
   int          m_idx;
   bit          m_done;

   function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] ben);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (ben[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(int cfg, logic [4:0] a);
      bit zr, byp;
      logic [31:0] v;
      zr  = (cfg == 0);
      byp = (cfg == 0);
      if (m_clear) return 32'h0;
      if (zr && a == 5'd0) return 32'h0;
      v = m_mem[cfg][a];
      if (byp && we && !clr && wa == a && !(zr && wa == 5'd0)) v = merge(v, wd, be);
      return v;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_clear = 1'b1; m_idx = 0; m_done = 1'b0;
      end else if (ce) begin
         m_done = 1'b0;
         if (m_clear) begin
            m_mem[0][m_idx] = 32'h0;
            m_mem[1][m_idx] = 32'h0;
            m_idx++;
            if (m_idx == 32) begin m_clear = 1'b0; m_done = 1'b1; end
         end else if (clr) begin
            m_clear = 1'b1; m_idx = 0;
         end else if (we) begin
            if (wa != 5'd0) m_mem[0][wa] = merge(m_mem[0][wa], wd, be);
            m_mem[1][wa] = merge(m_mem[1][wa], wd, be);
         end
      end
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One clock: compare reads before the edge, advance model, compare status after.
   task automatic cycle();
      #1;
      for (int p = 0; p < 2; p++) begin
         check("rd_a_model", rd_a[p*32 +: 32], m_read(0, ra[p*5 +: 5]));
         check("rd_b_model", rd_b[p*32 +: 32], m_read(1, ra[p*5 +: 5]));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("busy_a_model", 32'(busy_a), 32'(m_clear));
      check("busy_b_model", 32'(busy_b), 32'(m_clear));
      check("done_a_model", 32'(done_a), 32'(m_done));
      check("done_b_model", 32'(done_b), 32'(m_done));
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done_a !== 1'b1 && n < 100) begin cycle(); n++; end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [4:0]  ra0, ra1;
      logic [31:0] ea0, ea1, eb0, eb1;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int n;
      tbl[0] = '{1'b1, 5'd5,  32'hAABBCCDD, 4'hF, 5'd5,  5'd0,  32'hAABBCCDD, 32'h0,        32'h0,        32'h0};
      tbl[1] = '{1'b1, 5'd5,  32'h11223344, 4'h5, 5'd5,  5'd5,  32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD, 32'hAABBCCDD};
      tbl[2] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd5,  5'd7,  32'hAA22CC44, 32'h0,        32'hAA22CC44, 32'h0};
      tbl[3] = '{1'b1, 5'd7,  32'hDEADBEEF, 4'hF, 5'd7,  5'd5,  32'hDEADBEEF, 32'hAA22CC44, 32'h0,        32'hAA22CC44};
      tbl[4] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
      tbl[5] = '{1'b1, 5'd0,  32'h12345678, 4'hF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0};
      tbl[6] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd0,  5'd7,  32'h0,        32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
      tbl[7] = '{1'b1, 5'd9,  32'hCAFEF00D, 4'h0, 5'd9,  5'd0,  32'h0,        32'h0,        32'h0,        32'h12345678};
      tbl[8] = '{1'b1, 5'd31, 32'hFFFFFFFF, 4'h8, 5'd31, 5'd9,  32'hFF000000, 32'h0,        32'h0,        32'h0};
      tbl[9] = '{1'b0, 5'd0,  32'h0,        4'h0, 5'd31, 5'd31, 32'hFF000000, 32'hFF000000, 32'hFF000000, 32'hFF000000};

      for (int c = 0; c < 2; c++) for (int i = 0; i < 32; i++) m_mem[c][i] = 32'h0;
      rst = 1'b1; ce = 1'b1; we = 1'b0; clr = 1'b0;
      wa = '0; wd = '0; be = '0; ra = '0;

      // Reset clear: Busy for 32 cycles, ClearDone in cycle 33, then all zero.
      @(posedge clk);
      model_edge();
      @(negedge clk);
      rst = 1'b0;
      check("reset_busy", 32'(busy_a), 32'h1);
      check("reset_done", 32'(done_a), 32'h0);
      wait_done(n);
      check("reset_clear_latency", 32'(n), 32'd32);
      cycle();
      check("done_one_cycle", 32'(done_a), 32'h0);
      for (int a = 0; a < 32; a++) begin
         ra = {5'(a), 5'(a)};
         #1;
         check("cleared_a", rd_a[31:0], 32'h0);
         check("cleared_b", rd_b[63:32], 32'h0);
      end

      // Byte write, bypass and zero-register vectors.
      for (int i = 0; i < 10; i++) begin
         we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; be = tbl[i].be;
         ra = {tbl[i].ra1, tbl[i].ra0};
         #1;
         check("vec_a0", rd_a[31:0],  tbl[i].ea0);
         check("vec_a1", rd_a[63:32], tbl[i].ea1);
         check("vec_b0", rd_b[31:0],  tbl[i].eb0);
         check("vec_b1", rd_b[63:32], tbl[i].eb1);
         cycle();
      end

      // ClearReq collides with a write to reg 3; writes to reg 4 during clear drop.
      we = 1'b1; wa = 5'd3; wd = 32'h55555555; be = 4'hF; clr = 1'b1;
      ra = {5'd4, 5'd3};
      #1;
      check("collide_no_bypass", rd_a[31:0], 32'h0);
      cycle();
      check("collide_busy", 32'(busy_a), 32'h1);
      wa = 5'd4; wd = 32'h66666666;
      wait_done(n);
      check("clearreq_ignored_latency", 32'(n), 32'd32);
      we = 1'b0; clr = 1'b0;
      #1;
      check("reg3_a", rd_a[31:0],  32'h0);
      check("reg4_a", rd_a[63:32], 32'h0);
      check("reg3_b", rd_b[31:0],  32'h0);
      check("reg4_b", rd_b[63:32], 32'h0);

      // ClockEnable stall at counter 10 delays completion.
      clr = 1'b1; cycle(); clr = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      ce = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("stall_busy", 32'(busy_a), 32'h1);
         check("stall_done", 32'(done_a), 32'h0);
      end
      ce = 1'b1;
      wait_done(n);
      check("stall_remaining", 32'(n), 32'd22);
      ce = 1'b0;
      cycle(); check("done_hold1", 32'(done_a), 32'h1);
      cycle(); check("done_hold2", 32'(done_a), 32'h1);
      ce = 1'b1;
      cycle(); check("done_release", 32'(done_a), 32'h0);

      // Reset at counter 20 restarts the clear.
      clr = 1'b1; cycle(); clr = 1'b0;
      for (int i = 0; i < 20; i++) cycle();
      rst = 1'b1; cycle(); rst = 1'b0;
      check("midclear_reset_busy", 32'(busy_a), 32'h1);
      wait_done(n);
      check("midclear_reset_latency", 32'(n), 32'd32);

      // Randomised traffic against the model.
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         ce  = ($urandom_range(0, 7) != 0);
         clr = ($urandom_range(0, 79) == 0);
         we  = 1'($urandom);
         wa  = 5'($urandom);
         wd  = $urandom;
         be  = 4'($urandom);
         ra  = 10'($urandom);
         if ($urandom_range(0, 2) == 0) ra[4:0] = wa;
         if ($urandom_range(0, 4) == 0) ra[9:5] = ra[4:0];
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
